// File: rtl/button_conditioner_if.sv
// Button conditioner CPU-side bundle:
// pending event flags, debounced levels and acknowledge.
interface button_conditioner_if;
  logic [3:0] ack;
  logic       moveLeft;
  logic       moveRight;
  logic       rotate;
  logic       softDrop;
  logic [3:0] pressed;

  modport master (
    input  ack,
    output moveLeft, moveRight, rotate, softDrop,
    output pressed
  );

  modport slave (
    output ack,
    input  moveLeft, moveRight, rotate, softDrop,
    input  pressed
  );
endinterface

// File: rtl/button_conditioner.sv
// Four-button front end: sync, debounce, press/auto-repeat
// FSM per button and sticky pending flags cleared by ack.
module button_conditioner #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         REPEAT_DELAY    = 5000000,
  parameter int         REPEAT_PERIOD   = 2500000,
  parameter logic [3:0] REPEAT_MASK     = 4'b1011
) (
  input logic clk25,
  input logic CPU_RESETN,
  input logic BTNL,
  input logic BTNR,
  input logic BTNU,
  input logic BTND,
  button_conditioner_if.master cpu
);

  localparam int MAXA = (DEBOUNCE_CYCLES > REPEAT_DELAY) ?
                        DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP = (MAXA > REPEAT_PERIOD) ?
                        MAXA : REPEAT_PERIOD;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } state_t;

  logic [3:0]    raw;
  logic [3:0]    sync1;
  logic [3:0]    sync2;
  logic [3:0]    deb;
  logic [3:0]    pend;
  logic [3:0]    evtRaw;
  logic [3:0]    evt;
  logic          lrBoth;
  logic [CW-1:0] dbCnt    [4];
  logic [CW-1:0] timer    [4];
  logic [CW-1:0] timerNxt [4];
  state_t        state    [4];
  state_t        stateNxt [4];

  assign raw = {BTND, BTNU, BTNR, BTNL};

  always_ff @(posedge clk25 or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk25 or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          dbCnt[i] <= '0;
        end else if (dbCnt[i] == DB_LAST) begin
          deb[i]   <= ~deb[i];
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + ONE;
        end
      end
    end
  end

  always_ff @(posedge clk25 or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        timer[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state[i] <= stateNxt[i];
        timer[i] <= timerNxt[i];
      end
    end
  end

  // Release wins over a same-cycle repeat tick.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      stateNxt[i] = state[i];
      timerNxt[i] = timer[i];
      evtRaw[i]   = 1'b0;
      unique case (state[i])
        IDLE: begin
          timerNxt[i] = '0;
          if (deb[i]) begin
            evtRaw[i]   = 1'b1;
            stateNxt[i] = HOLD;
          end
        end
        HOLD: begin
          if (!deb[i]) begin
            stateNxt[i] = IDLE;
          end else if (timer[i] == DLY_LAST) begin
            if (REPEAT_MASK[i]) begin
              evtRaw[i]   = 1'b1;
              stateNxt[i] = REPEAT;
              timerNxt[i] = '0;
            end
          end else begin
            timerNxt[i] = timer[i] + ONE;
          end
        end
        REPEAT: begin
          if (!deb[i]) begin
            stateNxt[i] = IDLE;
          end else if (timer[i] == PER_LAST) begin
            evtRaw[i]   = 1'b1;
            timerNxt[i] = '0;
          end else begin
            timerNxt[i] = timer[i] + ONE;
          end
        end
        default: stateNxt[i] = IDLE;
      endcase
    end
  end

  // Left+right together is a chord: no moves.
  assign lrBoth = deb[0] & deb[1];
  assign evt    = evtRaw & ~{2'b00, {2{lrBoth}}};

  always_ff @(posedge clk25 or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      pend <= '0;
    end else begin
      pend <= evt | (pend & ~cpu.ack);
    end
  end

  assign cpu.moveLeft  = pend[0];
  assign cpu.moveRight = pend[1];
  assign cpu.rotate    = pend[2];
  assign cpu.softDrop  = pend[3];
  assign cpu.pressed   = deb;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, corner
// sequences and random stimulus against a hold-time model.
module tb_button_conditioner;

  localparam int         DC   = 4;
  localparam int         DLY  = 10;
  localparam int         PER  = 5;
  localparam logic [3:0] MASK = 4'b1011;

  logic clk25 = 1'b0;
  logic CPU_RESETN = 1'b0;
  logic BTNL = 1'b0;
  logic BTNR = 1'b0;
  logic BTNU = 1'b0;
  logic BTND = 1'b0;

  button_conditioner_if bus ();

  button_conditioner #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (DLY),
    .REPEAT_PERIOD  (PER),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk25     (clk25),
    .CPU_RESETN(CPU_RESETN),
    .BTNL      (BTNL),
    .BTNR      (BTNR),
    .BTNU      (BTNU),
    .BTND      (BTND),
    .cpu       (bus.master)
  );

  always #5 clk25 = ~clk25;

  int total = 0;
  int bad   = 0;

  // Model: a button's level is the raw input two edges
  // late, accepted after DC straight differing samples;
  // events fire at hold ages 0, DLY, DLY+PER, ...
  bit   rawHist [4][8192];
  int   cyc;
  bit   mDeb  [4];
  int   mFlip [4];
  int   mAge  [4];
  logic [3:0] mPend;

  function automatic bit samp(int b, int idx);
    if (idx < 2) return 1'b0;
    return rawHist[b][idx-2];
  endfunction

  function automatic logic [3:0] pendOut();
    return {bus.softDrop, bus.rotate, bus.moveRight, bus.moveLeft};
  endfunction

  task automatic modelReset();
    cyc   = 0;
    mPend = '0;
    for (int b = 0; b < 4; b++) begin
      mDeb[b]  = 1'b0;
      mFlip[b] = -1;
      mAge[b]  = 0;
    end
  endtask

  task automatic modelEdge(input logic [3:0] r, input logic [3:0] a);
    logic [3:0] ev;
    bit         d [4];
    bit         allDiff;
    int         idx;
    for (int b = 0; b < 4; b++) begin
      d[b]  = mDeb[b];
      ev[b] = d[b] && (mAge[b] == 0 ||
              (MASK[b] && mAge[b] >= DLY && (mAge[b] - DLY) % PER == 0));
    end
    if (d[0] && d[1]) ev[1:0] = 2'b00;
    mPend = ev | (mPend & ~a);
    for (int b = 0; b < 4; b++) begin
      mAge[b] = d[b] ? mAge[b] + 1 : 0;
      rawHist[b][cyc] = r[b];
      allDiff = 1'b1;
      for (int k = 0; k < DC; k++) begin
        idx = cyc - k;
        if (idx < 0 || idx <= mFlip[b]) allDiff = 1'b0;
        else if (samp(b, idx) == mDeb[b]) allDiff = 1'b0;
      end
      if (allDiff) begin
        mDeb[b]  = ~mDeb[b];
        mFlip[b] = cyc;
      end
    end
    cyc++;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] a);
    {BTND, BTNU, BTNR, BTNL} = r;
    bus.ack = a;
    @(posedge clk25);
    modelEdge(r, a);
    #1;
  endtask

  task automatic resetDut(input logic [3:0] r);
    {BTND, BTNU, BTNR, BTNL} = r;
    bus.ack = '0;
    CPU_RESETN = 1'b0;
    #1;
    check("rst_pend", pendOut(), 0);
    check("rst_pressed", bus.pressed, 0);
    @(posedge clk25);
    @(posedge clk25);
    @(negedge clk25);
    CPU_RESETN = 1'b1;
    modelReset();
  endtask

  typedef struct {
    logic [3:0] raw;
    logic [3:0] ack;
    logic [3:0] expPressed;
    logic [3:0] expPend;
  } vec_t;

  vec_t tbl [25];
  int   rises [$];
  int   expRep [7] = '{6, 16, 21, 26, 31, 36, 41};

  task automatic holdRun(input int b, input int holdCyc, input int runCyc);
    logic [3:0] r;
    logic [3:0] a;
    bit         prev;
    bit         cur;
    resetDut('0);
    rises.delete();
    prev = 1'b0;
    a    = '0;
    for (int k = 0; k < runCyc; k++) begin
      r = (k < holdCyc) ? 4'(1 << b) : 4'b0000;
      step(r, a);
      cur = pendOut()[b];
      if (cur && !prev) rises.push_back(k);
      a    = cur ? 4'(1 << b) : 4'b0000;
      prev = cur;
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] a;

    for (int i = 0; i < 25; i++) begin
      tbl[i].raw = 4'b0000;
      tbl[i].ack = 4'b0000;
      tbl[i].expPressed = 4'b0000;
      tbl[i].expPend = 4'b0000;
    end
    for (int i = 0; i < 8; i++) tbl[i].raw = 4'b0001;
    for (int i = 5; i < 13; i++) tbl[i].expPressed = 4'b0001;
    tbl[6].expPend = 4'b0001;
    tbl[7].ack = 4'b0001;
    for (int i = 14; i < 17; i++) tbl[i].raw = 4'b0010;

    bus.ack = '0;
    modelReset();

    resetDut('0);
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].raw, tbl[i].ack);
      check($sformatf("tbl%0d_pressed", i), bus.pressed, tbl[i].expPressed);
      check($sformatf("tbl%0d_pend", i), pendOut(), tbl[i].expPend);
    end

    holdRun(0, 40, 60);
    check("L_riseCnt", rises.size(), 7);
    for (int i = 0; i < rises.size() && i < 7; i++)
      check($sformatf("L_rise%0d", i), rises[i], expRep[i]);

    holdRun(2, 60, 70);
    check("U_riseCnt", rises.size(), 1);
    if (rises.size() > 0) check("U_rise0", rises[0], 6);

    holdRun(3, 40, 60);
    check("D_riseCnt", rises.size(), 7);
    for (int i = 0; i < rises.size() && i < 7; i++)
      check($sformatf("D_rise%0d", i), rises[i], expRep[i]);

    resetDut('0);
    for (int k = 0; k < 26; k++) begin
      r = (k < 12) ? 4'b0011 : 4'b0001;
      step(r, '0);
      if (k == 6) check("LR_pressed", bus.pressed, 4'b0011);
      if (k >= 6 && k < 21) check($sformatf("LR_quiet%0d", k), pendOut(), 0);
      if (k == 21) check("LR_resume", pendOut(), 4'b0001);
      if (k == 25) check("LR_pressedL", bus.pressed, 4'b0001);
    end

    resetDut('0);
    for (int k = 0; k < 23; k++) step(4'b0001, '0);
    check("RR_pendBefore", pendOut(), 4'b0001);
    resetDut(4'b0001);
    for (int k = 0; k < 7; k++) begin
      step(4'b0001, '0);
      if (k == 5) check("RR_pressed5", bus.pressed, 4'b0001);
      if (k < 6) check($sformatf("RR_wait%0d", k), pendOut(), 0);
      else check("RR_event", pendOut(), 4'b0001);
    end

    resetDut('0);
    r = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      for (int b = 0; b < 4; b++)
        a[b] = ($urandom_range(0, 3) == 0);
      step(r, a);
      check($sformatf("rand%0d", k), {bus.pressed, pendOut()},
            {mDeb[3], mDeb[2], mDeb[1], mDeb[0], mPend});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
